tape_deck: RTL and testbench

TAPE_DECK -- requirements
Module: tape_deck

---
 rtl/tape_deck.sv | 252 +++++++++++++++++++++++++
 tb/tb_tape_deck.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_deck.sv
// Cassette tape deck: plays a RAM tape image as a pulse-width coded level and
// records such a level back into the RAM (start, 8 data LSB first, odd parity, stop bits).
module tape_deck #(
    parameter int ADDR_W      = 16,
    parameter int UNIT_CYCLES = 2083,
    parameter int STOP_BITS   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              en,
    input  logic              rewind,
    input  logic [ADDR_W-1:0] tape_end,
    output logic [ADDR_W-1:0] tape_addr,
    input  logic [7:0]        tape_data,
    output logic              tape_wr,
    output logic [7:0]        tape_dout,
    input  logic              rec_in,
    output logic              data,
    output logic              at_end,
    output logic [ADDR_W-1:0] rec_len,
    output logic              parity_err
);

    localparam int CW = $clog2(4 * UNIT_CYCLES + 1);
    localparam logic [CW-1:0] UNIT_M1  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] UNIT2_M1 = CW'(2 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] SAT      = CW'(4 * UNIT_CYCLES);
    localparam logic [CW-1:0] SAT_M1   = CW'(4 * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] THR      = CW'((3 * UNIT_CYCLES) / 2);
    localparam logic [4:0]    LAST_BIT = 5'(9 + STOP_BITS);
    localparam logic [ADDR_W-1:0] REC_MAX = '1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, BIT_HI, BIT_LO, DONE} pstate_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_PAR} rstate_t;

    pstate_t           pstate_q, pstate_d;
    logic [CW-1:0]     pcnt_q, pcnt_d;
    logic [4:0]        pbit_q, pbit_d;
    logic [7:0]        pbyte_q, pbyte_d;
    logic              more_q, more_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    rstate_t           rstate_q, rstate_d;
    logic [CW-1:0]     rcnt_q, rcnt_d;
    logic [2:0]        rbits_q, rbits_d;
    logic [7:0]        rbyte_q, rbyte_d;
    logic              wr_q, wr_d;
    logic [7:0]        dout_q, dout_d;
    logic [ADDR_W-1:0] rec_len_q, rec_len_d;
    logic              perr_q, perr_d;
    logic              rec_q;
    logic              mode_q;

    logic              mode_chg;
    logic              cur_bit;
    logic [2:0]        bidx;
    logic              bit_vld, bit_val;

    assign mode_chg = (mode != mode_q);
    assign bidx     = pbit_q[2:0] - 3'd1;

    // Bit index 0 is the start bit, 1..8 data, 9 parity, the rest stop bits.
    always_comb begin
        cur_bit = 1'b1;
        if (pbit_q == 5'd0)
            cur_bit = 1'b0;
        else if (pbit_q <= 5'd8)
            cur_bit = pbyte_q[bidx];
        else if (pbit_q == 5'd9)
            cur_bit = ~^pbyte_q;
    end

    always_comb begin
        pstate_d = pstate_q;
        pcnt_d   = pcnt_q;
        pbit_d   = pbit_q;
        pbyte_d  = pbyte_q;
        more_d   = more_q;
        addr_d   = addr_q;
        if (rewind) begin
            pstate_d = IDLE;
            pcnt_d   = '0;
            pbit_d   = '0;
            more_d   = 1'b0;
            addr_d   = '0;
        end else if (mode_chg) begin
            pstate_d = IDLE;
            pcnt_d   = '0;
            pbit_d   = '0;
        end else if (en && !mode) begin
            case (pstate_q)
                IDLE:  pstate_d = FETCH;
                FETCH: pstate_d = LOAD;
                LOAD: begin
                    pbyte_d  = tape_data;
                    pbit_d   = '0;
                    pcnt_d   = '0;
                    pstate_d = BIT_HI;
                end
                BIT_HI: begin
                    if (pcnt_q == UNIT_M1) begin
                        pcnt_d   = '0;
                        pstate_d = BIT_LO;
                        // Prefetch the next byte while the last stop bit is low.
                        if (pbit_q == LAST_BIT) begin
                            more_d = (addr_q != tape_end);
                            if (addr_q != tape_end)
                                addr_d = addr_q + 1'b1;
                        end
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                BIT_LO: begin
                    if (pcnt_q == (cur_bit ? UNIT_M1 : UNIT2_M1)) begin
                        pcnt_d = '0;
                        if (pbit_q != LAST_BIT) begin
                            pbit_d   = pbit_q + 1'b1;
                            pstate_d = BIT_HI;
                        end else if (more_q) begin
                            pbyte_d  = tape_data;
                            pbit_d   = '0;
                            pstate_d = BIT_HI;
                        end else begin
                            pstate_d = DONE;
                        end
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
                DONE:    pstate_d = DONE;
                default: pstate_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rstate_d  = rstate_q;
        rcnt_d    = rcnt_q;
        rbits_d   = rbits_q;
        rbyte_d   = rbyte_q;
        wr_d      = 1'b0;
        dout_d    = dout_q;
        perr_d    = perr_q;
        rec_len_d = rec_len_q + ADDR_W'(wr_q);
        bit_vld   = 1'b0;
        bit_val   = 1'b0;
        if (rewind) begin
            rstate_d = R_IDLE;
            rcnt_d   = '0;
            rbits_d  = '0;
            if (mode) begin
                rec_len_d = '0;
                perr_d    = 1'b0;
            end
        end else if (mode_chg) begin
            rstate_d = R_IDLE;
            rcnt_d   = '0;
        end else if (en && mode) begin
            if (rec_q && !rec_in) begin
                rcnt_d = CW'(1);
            end else if (!rec_in) begin
                // A saturated low is a dropout, never a data bit.
                if (rcnt_q != '0 && rcnt_q != SAT) begin
                    rcnt_d = rcnt_q + 1'b1;
                    if (rcnt_q == SAT_M1)
                        rstate_d = R_IDLE;
                end
            end else if (!rec_q) begin
                rcnt_d = '0;
                if (rcnt_q != '0 && rcnt_q != SAT) begin
                    bit_vld = 1'b1;
                    bit_val = (rcnt_q < THR);
                end
            end
            if (bit_vld) begin
                case (rstate_q)
                    R_IDLE: begin
                        if (!bit_val) begin
                            rstate_d = R_DATA;
                            rbits_d  = '0;
                        end
                    end
                    R_DATA: begin
                        rbyte_d = {bit_val, rbyte_q[7:1]};
                        rbits_d = rbits_q + 1'b1;
                        if (rbits_q == 3'd7)
                            rstate_d = R_PAR;
                    end
                    R_PAR: begin
                        rstate_d = R_IDLE;
                        if (!(^{rbyte_q, bit_val}))
                            perr_d = 1'b1;
                        if (rec_len_q != REC_MAX) begin
                            wr_d   = 1'b1;
                            dout_d = rbyte_q;
                        end
                    end
                    default: rstate_d = R_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pstate_q  <= IDLE;
            pcnt_q    <= '0;
            pbit_q    <= '0;
            pbyte_q   <= '0;
            more_q    <= 1'b0;
            addr_q    <= '0;
            rstate_q  <= R_IDLE;
            rcnt_q    <= '0;
            rbits_q   <= '0;
            rbyte_q   <= '0;
            wr_q      <= 1'b0;
            dout_q    <= '0;
            rec_len_q <= '0;
            perr_q    <= 1'b0;
            rec_q     <= 1'b1;
            mode_q    <= 1'b0;
        end else begin
            pstate_q  <= pstate_d;
            pcnt_q    <= pcnt_d;
            pbit_q    <= pbit_d;
            pbyte_q   <= pbyte_d;
            more_q    <= more_d;
            addr_q    <= addr_d;
            rstate_q  <= rstate_d;
            rcnt_q    <= rcnt_d;
            rbits_q   <= rbits_d;
            rbyte_q   <= rbyte_d;
            wr_q      <= wr_d;
            dout_q    <= dout_d;
            rec_len_q <= rec_len_d;
            perr_q    <= perr_d;
            rec_q     <= rec_in;
            mode_q    <= mode;
        end
    end

    assign tape_addr  = mode ? rec_len_q : addr_q;
    assign tape_wr    = wr_q & ~rewind;
    assign tape_dout  = dout_q;
    assign rec_len    = rec_len_q;
    assign parity_err = perr_q;
    assign data       = (pstate_q != BIT_LO);
    assign at_end     = (pstate_q == DONE);

endmodule

// File: tb/tb_tape_deck.sv
// Bench for tape_deck: random bytes played and recorded against a frame/waveform model.
module tb_tape_deck;
    localparam int U  = 4;
    localparam int SB = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset, mode, en, rewind, rec_in;
    logic [AW-1:0] tape_end, tape_addr, rec_len;
    logic [7:0]    tape_data, tape_dout;
    logic          tape_wr, data, at_end, parity_err;

    logic [7:0]    mem [16];
    logic [7:0]    pbytes[$];
    logic          wave[$];
    int            frame0_len;
    logic [AW-1:0] wa[$];
    logic [7:0]    wd[$];
    int            checks = 0;
    int            errors = 0;

    tape_deck #(.ADDR_W(AW), .UNIT_CYCLES(U), .STOP_BITS(SB)) dut (
        .clk(clk), .reset(reset), .mode(mode), .en(en), .rewind(rewind),
        .tape_end(tape_end), .tape_addr(tape_addr), .tape_data(tape_data),
        .tape_wr(tape_wr), .tape_dout(tape_dout), .rec_in(rec_in),
        .data(data), .at_end(at_end), .rec_len(rec_len), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tape_data <= mem[tape_addr];

    always @(negedge clk) begin
        if (tape_wr) begin
            wa.push_back(tape_addr);
            wd.push_back(tape_dout);
        end
    end

    // Reference frame: start 0, data LSB first, odd parity, stop 1s; each bit is
    // U cycles high then U (bit 1) or 2U (bit 0) cycles low.
    task automatic append_frame(input logic [7:0] b, input bit flip);
        logic bits[$];
        logic par;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        par = (($countones(b) % 2) == 0);
        bits.push_back(flip ? ~par : par);
        for (int i = 0; i < SB; i++) bits.push_back(1'b1);
        foreach (bits[i]) begin
            repeat (U) wave.push_back(1'b1);
            repeat (bits[i] ? U : 2 * U) wave.push_back(1'b0);
        end
    endtask

    task automatic setup_play();
        mode = 1'b0; en = 1'b0; rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        foreach (pbytes[i]) mem[i] = pbytes[i];
        tape_end = AW'(pbytes.size() - 1);
        wave.delete();
        foreach (pbytes[i]) begin
            append_frame(pbytes[i], 1'b0);
            if (i == 0) frame0_len = wave.size();
        end
    endtask

    task automatic run_play(input string name, input bit do_pause);
        int pk;
        int cand[$];
        logic exp[$];
        setup_play();
        pk = -1;
        if (do_pause) begin
            for (int k = 0; k < wave.size() - 1; k++)
                if (!wave[k] && !wave[k+1]) cand.push_back(k);
            pk = cand[$urandom_range(0, cand.size() - 1)];
        end
        exp.push_back(1'b1);
        exp.push_back(1'b1);
        foreach (wave[k]) begin
            exp.push_back(wave[k]);
            if (k == pk) repeat (50) exp.push_back(wave[k]);
        end
        en = 1'b1;
        for (int i = 0; i < exp.size(); i++) begin
            @(negedge clk);
            checks++;
            if (data !== exp[i]) begin
                errors++;
                $display("FAIL %s data cycle %0d got %b want %b", name, i, data, exp[i]);
            end
            if (i == exp.size() - 1) begin
                checks++;
                if (at_end !== 1'b0) begin
                    errors++;
                    $display("FAIL %s at_end early got %b want 0", name, at_end);
                end
            end
            if (pk >= 0 && i == 2 + pk) en = 1'b0;
            if (pk >= 0 && i == 2 + pk + 50) en = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (at_end !== 1'b1 || data !== 1'b1) begin
            errors++;
            $display("FAIL %s end got at_end=%b data=%b want 1 1", name, at_end, data);
        end
        checks++;
        if (tape_addr !== tape_end) begin
            errors++;
            $display("FAIL %s end addr got %0d want %0d", name, tape_addr, tape_end);
        end
        en = 1'b0;
    endtask

    task automatic send_wave();
        foreach (wave[k]) begin
            rec_in = wave[k];
            @(negedge clk);
        end
        rec_in = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic rec_start();
        mode = 1'b1; en = 1'b1; rewind = 1'b1; rec_in = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        wa.delete(); wd.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tape_addr !== '0 || data !== 1'b1 || at_end !== 1'b0 || tape_wr !== 1'b0 ||
            tape_dout !== 8'h00 || rec_len !== '0 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset got addr=%0d data=%b end=%b wr=%b dout=%h len=%0d perr=%b want 0 1 0 0 00 0 0",
                     tape_addr, data, at_end, tape_wr, tape_dout, rec_len, parity_err);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_play_zero();
        pbytes = '{8'h00};
        run_play("play_00", 1'b0);
    endtask

    task automatic test_back_to_back();
        pbytes = '{8'hA5, 8'hFF};
        run_play("play_a5ff", 1'b0);
    endtask

    task automatic test_play_pause();
        pbytes = '{8'($urandom)};
        run_play("play_pause", 1'b1);
    endtask

    task automatic test_play_random();
        pbytes = '{8'($urandom), 8'($urandom), 8'($urandom)};
        run_play("play_rand", 1'b1);
    endtask

    task automatic test_rewind_midplay();
        int idx;
        pbytes = '{8'($urandom), 8'($urandom)};
        setup_play();
        idx = 2 + frame0_len + U + 1;
        en = 1'b1;
        repeat (idx + 1) @(negedge clk);
        checks++;
        if (tape_addr !== 4'd1 || data !== wave[idx-2]) begin
            errors++;
            $display("FAIL rewind_pre got addr=%0d data=%b want 1 %b", tape_addr, data, wave[idx-2]);
        end
        rewind = 1'b1;
        @(negedge clk);
        checks++;
        if (tape_addr !== '0 || data !== 1'b1 || at_end !== 1'b0) begin
            errors++;
            $display("FAIL rewind got addr=%0d data=%b end=%b want 0 1 0", tape_addr, data, at_end);
        end
        rewind = 1'b0; en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_record_loop();
        rec_start();
        wave.delete();
        append_frame(8'h3C, 1'b0);
        send_wave();
        checks++;
        if (wa.size() !== 1 || wd[0] !== 8'h3C || wa[0] !== '0) begin
            errors++;
            $display("FAIL rec_3c got writes=%0d dat=%h addr=%0d want 1 3c 0", wa.size(), wd[0], wa[0]);
        end
        checks++;
        if (rec_len !== 4'd1 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL rec_3c_len got len=%0d perr=%b want 1 0", rec_len, parity_err);
        end
    endtask

    task automatic test_record_parity();
        logic [7:0] b;
        b = 8'($urandom);
        rec_start();
        wave.delete();
        append_frame(b, 1'b1);
        send_wave();
        checks++;
        if (wa.size() !== 1 || wd[0] !== b || parity_err !== 1'b1) begin
            errors++;
            $display("FAIL rec_par got writes=%0d dat=%h perr=%b want 1 %h 1", wa.size(), wd[0], parity_err, b);
        end
        wave.delete();
        append_frame(8'($urandom), 1'b0);
        send_wave();
        checks++;
        if (parity_err !== 1'b1 || rec_len !== 4'd2) begin
            errors++;
            $display("FAIL rec_par_sticky got perr=%b len=%0d want 1 2", parity_err, rec_len);
        end
        rewind = 1'b1;
        @(negedge clk);
        rewind = 1'b0;
        checks++;
        if (parity_err !== 1'b0 || rec_len !== '0) begin
            errors++;
            $display("FAIL rec_par_rewind got perr=%b len=%0d want 0 0", parity_err, rec_len);
        end
    endtask

    task automatic test_record_abort();
        logic [7:0] b;
        rec_start();
        wave.delete();
        append_frame(8'($urandom), 1'b0);
        send_wave();
        wave.delete();
        append_frame(8'($urandom), 1'b0);
        for (int k = 0; k < 4 * U; k++) begin
            rec_in = wave[k];
            @(negedge clk);
        end
        rec_in = 1'b0;
        repeat (20) @(negedge clk);
        rec_in = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (wa.size() !== 1 || rec_len !== 4'd1) begin
            errors++;
            $display("FAIL rec_abort got writes=%0d len=%0d want 1 1", wa.size(), rec_len);
        end
        b = 8'($urandom);
        wave.delete();
        append_frame(b, 1'b0);
        send_wave();
        checks++;
        if (wa.size() !== 2 || wd[1] !== b || wa[1] !== 4'd1 || rec_len !== 4'd2) begin
            errors++;
            $display("FAIL rec_after_abort got writes=%0d dat=%h addr=%0d len=%0d want 2 %h 1 2",
                     wa.size(), wd[wd.size()-1], wa[wa.size()-1], rec_len, b);
        end
    endtask

    task automatic test_record_saturate();
        logic [7:0] ew[$];
        logic [7:0] b;
        bit flip;
        bit perr;
        perr = 1'b0;
        rec_start();
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            flip = (i < 15) && ($urandom_range(0, 3) == 0);
            perr |= flip;
            wave.delete();
            append_frame(b, flip);
            send_wave();
            if (i < 15) ew.push_back(b);
        end
        checks++;
        if (wa.size() !== ew.size()) begin
            errors++;
            $display("FAIL rec_sat_count got %0d want %0d", wa.size(), ew.size());
        end
        for (int i = 0; i < ew.size() && i < wa.size(); i++) begin
            checks++;
            if (wd[i] !== ew[i] || wa[i] !== AW'(i)) begin
                errors++;
                $display("FAIL rec_sat_wr%0d got %h@%0d want %h@%0d", i, wd[i], wa[i], ew[i], i);
            end
        end
        checks++;
        if (rec_len !== 4'd15 || parity_err !== perr) begin
            errors++;
            $display("FAIL rec_sat_len got len=%0d perr=%b want 15 %b", rec_len, parity_err, perr);
        end
    endtask

    task automatic test_reset_midframe();
        mode = 1'b1; en = 1'b1;
        wa.delete(); wd.delete();
        wave.delete();
        append_frame(8'($urandom), 1'b0);
        for (int k = 0; k < 60; k++) begin
            rec_in = wave[k];
            @(negedge clk);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rec_in = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (wa.size() !== 0 || rec_len !== '0 || parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got writes=%0d len=%0d perr=%b want 0 0 0", wa.size(), rec_len, parity_err);
        end
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; en = 1'b0; rewind = 1'b0; rec_in = 1'b1; tape_end = '0;
        foreach (mem[i]) mem[i] = 8'h00;
        test_reset();
        test_play_zero();
        test_back_to_back();
        test_play_pause();
        test_play_random();
        test_rewind_midplay();
        test_record_loop();
        test_record_parity();
        test_record_abort();
        test_record_saturate();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
